// File: rtl/ext_mem_arbiter.sv
// Two-requester arbiter for the shared 256-bit external line-fill port.
// D wins contention until I has been passed over MAX_STREAK times in a row.
module ext_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 256,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic              d_cs_i,
    input  logic              d_we_i,
    input  logic [DATA_W-1:0] d_data_i,
    output logic [DATA_W-1:0] d_data_o,
    output logic              d_ack_o,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic              i_cs_i,
    input  logic              i_we_i,
    input  logic [DATA_W-1:0] i_data_i,
    output logic [DATA_W-1:0] i_data_o,
    output logic              i_ack_o,
    output logic [ADDR_W-1:0] ext_mem_addr,
    output logic              ext_mem_cs,
    output logic              ext_mem_we,
    output logic [DATA_W-1:0] ext_mem_data_o,
    input  logic [DATA_W-1:0] ext_mem_data_i,
    input  logic              ext_mem_ack
);

    // state   | meaning
    // IDLE    | no grant, requests sampled every edge
    // GNT_D   | D owns the memory port, waiting for ext_mem_ack
    // GNT_I   | I owns the memory port, waiting for ext_mem_ack
    // RELEASE | ack pulse cycle; dead cycle keeps ext_mem_cs low for 2 cycles
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GNT_D   = 2'd1;
    localparam logic [1:0] GNT_I   = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    logic [1:0] state;
    logic [3:0] streak;
    logic       grant_d;
    logic       grant_i;

    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE) begin
            if (d_cs_i && !(i_cs_i && streak == STREAK_MAX)) begin
                grant_d = 1'b1;
            end else if (i_cs_i) begin
                grant_i = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            streak         <= '0;
            d_data_o       <= '0;
            d_ack_o        <= 1'b0;
            i_data_o       <= '0;
            i_ack_o        <= 1'b0;
            ext_mem_addr   <= '0;
            ext_mem_cs     <= 1'b0;
            ext_mem_we     <= 1'b0;
            ext_mem_data_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state          <= GNT_D;
                        ext_mem_cs     <= 1'b1;
                        ext_mem_addr   <= d_addr_i;
                        ext_mem_we     <= d_we_i;
                        ext_mem_data_o <= d_data_i;
                        // streak only grows while I is actually waiting
                        if (!i_cs_i) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + 4'd1;
                        end
                    end else if (grant_i) begin
                        state          <= GNT_I;
                        ext_mem_cs     <= 1'b1;
                        ext_mem_addr   <= i_addr_i;
                        ext_mem_we     <= i_we_i;
                        ext_mem_data_o <= i_data_i;
                        streak         <= '0;
                    end
                end
                GNT_D: begin
                    if (ext_mem_ack) begin
                        state          <= RELEASE;
                        d_ack_o        <= 1'b1;
                        if (!ext_mem_we) begin
                            d_data_o <= ext_mem_data_i;
                        end
                        ext_mem_cs     <= 1'b0;
                        ext_mem_we     <= 1'b0;
                        ext_mem_addr   <= '0;
                        ext_mem_data_o <= '0;
                    end
                end
                GNT_I: begin
                    if (ext_mem_ack) begin
                        state          <= RELEASE;
                        i_ack_o        <= 1'b1;
                        if (!ext_mem_we) begin
                            i_data_o <= ext_mem_data_i;
                        end
                        ext_mem_cs     <= 1'b0;
                        ext_mem_we     <= 1'b0;
                        ext_mem_addr   <= '0;
                        ext_mem_data_o <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    d_ack_o <= 1'b0;
                    i_ack_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Self-checking bench for ext_mem_arbiter: directed corner cases plus randomized
// contention checked against a transaction-level grant model.
module tb_ext_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 256;
    localparam int MAX_STREAK = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] d_addr_i, i_addr_i, ext_mem_addr;
    logic              d_cs_i, d_we_i, i_cs_i, i_we_i;
    logic [DATA_W-1:0] d_data_i, i_data_i, d_data_o, i_data_o;
    logic              d_ack_o, i_ack_o;
    logic              ext_mem_cs, ext_mem_we, ext_mem_ack;
    logic [DATA_W-1:0] ext_mem_data_o, ext_mem_data_i;

    int total = 0;
    int bad   = 0;

    // reference model state
    int                m_streak = 0;
    logic [DATA_W-1:0] d_last   = '0;
    logic [DATA_W-1:0] i_last   = '0;

    ext_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STREAK(MAX_STREAK)) dut (
        .clk(clk), .rst(rst),
        .d_addr_i(d_addr_i), .d_cs_i(d_cs_i), .d_we_i(d_we_i), .d_data_i(d_data_i),
        .d_data_o(d_data_o), .d_ack_o(d_ack_o),
        .i_addr_i(i_addr_i), .i_cs_i(i_cs_i), .i_we_i(i_we_i), .i_data_i(i_data_i),
        .i_data_o(i_data_o), .i_ack_o(i_ack_o),
        .ext_mem_addr(ext_mem_addr), .ext_mem_cs(ext_mem_cs), .ext_mem_we(ext_mem_we),
        .ext_mem_data_o(ext_mem_data_o), .ext_mem_data_i(ext_mem_data_i), .ext_mem_ack(ext_mem_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ack(input logic [DATA_W-1:0] rd);
        ext_mem_data_i = rd;
        ext_mem_ack    = 1'b1;
        tick();
        ext_mem_ack    = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] rand_line();
        logic [DATA_W-1:0] r;
        for (int k = 0; k < DATA_W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // I is granted under contention only once D has won MAX_STREAK times while I waited
    task automatic model_grant(input bit rd, input bit ri, output bit pick_i);
        pick_i = ri && (!rd || m_streak >= MAX_STREAK);
        if (pick_i || !ri) m_streak = 0;
        else m_streak = (m_streak + 1 > MAX_STREAK) ? MAX_STREAK : m_streak + 1;
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] rd;
        bit pick;
        rst = 1'b0; d_cs_i = 1'b1; i_cs_i = 1'b1;
        d_addr_i = 32'hD000_0100; i_addr_i = 32'h1000_0200;
        tick(); tick();
        total++; if (ext_mem_cs !== 1'b0) begin bad++; $display("FAIL rst_cs got=%0b exp=0", ext_mem_cs); end
        total++; if (d_ack_o !== 1'b0 || i_ack_o !== 1'b0) begin bad++; $display("FAIL rst_acks got=%0b%0b exp=00", d_ack_o, i_ack_o); end
        total++; if (ext_mem_addr !== '0) begin bad++; $display("FAIL rst_addr got=%0h exp=0", ext_mem_addr); end
        total++; if (d_data_o !== '0 || i_data_o !== '0) begin bad++; $display("FAIL rst_data got=%0h/%0h exp=0", d_data_o, i_data_o); end
        d_last = '0; i_last = '0; m_streak = 0;
        rst = 1'b1;
        tick();
        model_grant(1'b1, 1'b1, pick);
        total++; if (ext_mem_cs !== 1'b1) begin bad++; $display("FAIL rst_grant_cs got=%0b exp=1", ext_mem_cs); end
        total++; if (ext_mem_addr !== d_addr_i) begin bad++; $display("FAIL rst_grant_addr got=%0h exp=%0h", ext_mem_addr, d_addr_i); end
        i_cs_i = 1'b0;
        tick();
        rd = rand_line();
        do_ack(rd);
        d_last = rd;
        total++; if (d_ack_o !== 1'b1 || i_ack_o !== 1'b0) begin bad++; $display("FAIL rst_txn_ack got=%0b%0b exp=10", d_ack_o, i_ack_o); end
        total++; if (d_data_o !== d_last) begin bad++; $display("FAIL rst_txn_data got=%0h exp=%0h", d_data_o, d_last); end
        d_cs_i = 1'b0;
        tick();
        total++; if (d_ack_o !== 1'b0) begin bad++; $display("FAIL rst_txn_ack_drop got=%0b exp=0", d_ack_o); end
        tick();
    endtask

    task automatic test_d_read();
        logic [DATA_W-1:0] rd;
        bit pick;
        rd = {32{8'hA5}};
        d_addr_i = 32'h0000_0400; d_we_i = 1'b0; d_data_i = rand_line(); d_cs_i = 1'b1;
        tick();
        model_grant(1'b1, 1'b0, pick);
        total++; if (ext_mem_cs !== 1'b1 || ext_mem_we !== 1'b0) begin bad++; $display("FAIL dread_grant cs/we got=%0b%0b exp=10", ext_mem_cs, ext_mem_we); end
        total++; if (ext_mem_addr !== 32'h0000_0400) begin bad++; $display("FAIL dread_addr got=%0h exp=400", ext_mem_addr); end
        tick(); tick();
        total++; if (ext_mem_cs !== 1'b1) begin bad++; $display("FAIL dread_hold_cs got=%0b exp=1", ext_mem_cs); end
        do_ack(rd);
        d_last = rd;
        total++; if (d_ack_o !== 1'b1 || i_ack_o !== 1'b0) begin bad++; $display("FAIL dread_ack got=%0b%0b exp=10", d_ack_o, i_ack_o); end
        total++; if (d_data_o !== rd) begin bad++; $display("FAIL dread_data got=%0h exp=%0h", d_data_o, rd); end
        total++; if (ext_mem_cs !== 1'b0 || ext_mem_addr !== '0) begin bad++; $display("FAIL dread_release cs=%0b addr=%0h exp=0/0", ext_mem_cs, ext_mem_addr); end
        d_cs_i = 1'b0;
        tick();
        total++; if (d_ack_o !== 1'b0 || ext_mem_cs !== 1'b0) begin bad++; $display("FAIL dread_pulse ack=%0b cs=%0b exp=0/0", d_ack_o, ext_mem_cs); end
        tick();
        total++; if (ext_mem_cs !== 1'b0) begin bad++; $display("FAIL dread_idle_cs got=%0b exp=0", ext_mem_cs); end
    endtask

    task automatic test_i_write();
        bit pick;
        i_addr_i = 32'h1000_0800; i_we_i = 1'b1; i_data_i = 256'h1234; i_cs_i = 1'b1;
        tick();
        model_grant(1'b0, 1'b1, pick);
        total++; if (ext_mem_cs !== 1'b1 || ext_mem_we !== 1'b1) begin bad++; $display("FAIL iwr_grant cs/we got=%0b%0b exp=11", ext_mem_cs, ext_mem_we); end
        total++; if (ext_mem_data_o !== 256'h1234) begin bad++; $display("FAIL iwr_wdata got=%0h exp=1234", ext_mem_data_o); end
        total++; if (ext_mem_addr !== 32'h1000_0800) begin bad++; $display("FAIL iwr_addr got=%0h exp=10000800", ext_mem_addr); end
        tick();
        do_ack(rand_line());
        total++; if (i_ack_o !== 1'b1 || d_ack_o !== 1'b0) begin bad++; $display("FAIL iwr_ack got i=%0b d=%0b exp=1/0", i_ack_o, d_ack_o); end
        total++; if (i_data_o !== i_last) begin bad++; $display("FAIL iwr_rdata_held got=%0h exp=%0h", i_data_o, i_last); end
        total++; if (ext_mem_data_o !== '0 || ext_mem_we !== 1'b0) begin bad++; $display("FAIL iwr_release we=%0b data=%0h exp=0", ext_mem_we, ext_mem_data_o); end
        i_cs_i = 1'b0;
        tick();
        total++; if (i_ack_o !== 1'b0) begin bad++; $display("FAIL iwr_pulse got=%0b exp=0", i_ack_o); end
        tick();
    endtask

    task automatic test_starvation();
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_wdata, rd;
        logic              exp_we;
        bit                exp_i, got_i, pick;
        int                lows;
        d_addr_i = {4'hD, 28'($urandom)}; d_we_i = 1'($urandom); d_data_i = rand_line();
        i_addr_i = {4'h1, 28'($urandom)}; i_we_i = 1'($urandom); i_data_i = rand_line();
        d_cs_i = 1'b1; i_cs_i = 1'b1;
        for (int g = 0; g < 10; g++) begin
            lows = 0;
            tick();
            while (ext_mem_cs !== 1'b1 && lows < 20) begin lows++; tick(); end
            total++; if (ext_mem_cs !== 1'b1) begin bad++; $display("FAIL starve_grant_timeout g=%0d cs=%0b exp=1", g, ext_mem_cs); end
            if (g > 0) begin
                total++; if (lows + 1 != 2) begin bad++; $display("FAIL starve_gap g=%0d got=%0d exp=2", g, lows + 1); end
            end
            exp_i = (g % 5 == 4);
            model_grant(1'b1, 1'b1, pick);
            got_i = (ext_mem_addr[ADDR_W-1 -: 4] == 4'h1);
            total++; if (got_i !== exp_i) begin bad++; $display("FAIL starve_order g=%0d got_i=%0b exp_i=%0b", g, got_i, exp_i); end
            exp_addr  = exp_i ? i_addr_i : d_addr_i;
            exp_we    = exp_i ? i_we_i : d_we_i;
            exp_wdata = exp_i ? i_data_i : d_data_i;
            total++; if (ext_mem_we !== exp_we || ext_mem_data_o !== exp_wdata) begin bad++; $display("FAIL starve_fields g=%0d we=%0b exp=%0b", g, ext_mem_we, exp_we); end
            d_addr_i = {4'hD, 28'($urandom)}; d_we_i = 1'($urandom); d_data_i = rand_line();
            i_addr_i = {4'h1, 28'($urandom)}; i_we_i = 1'($urandom); i_data_i = rand_line();
            repeat ($urandom_range(0, 3)) tick();
            total++; if (ext_mem_addr !== exp_addr || ext_mem_cs !== 1'b1) begin bad++; $display("FAIL starve_hold g=%0d addr=%0h exp=%0h", g, ext_mem_addr, exp_addr); end
            rd = rand_line();
            do_ack(rd);
            if (exp_i && !exp_we) i_last = rd;
            if (!exp_i && !exp_we) d_last = rd;
            total++; if (d_ack_o !== !exp_i || i_ack_o !== exp_i) begin bad++; $display("FAIL starve_ack g=%0d got d=%0b i=%0b exp_i=%0b", g, d_ack_o, i_ack_o, exp_i); end
            total++; if (d_data_o !== d_last || i_data_o !== i_last) begin bad++; $display("FAIL starve_rdata g=%0d d=%0h i=%0h", g, d_data_o, i_data_o); end
        end
        d_cs_i = 1'b0; i_cs_i = 1'b0;
        tick(); tick();
    endtask

    task automatic test_corner();
        bit pick;
        ext_mem_data_i = rand_line(); ext_mem_ack = 1'b1;
        tick();
        ext_mem_ack = 1'b0;
        total++; if (d_ack_o !== 1'b0 || i_ack_o !== 1'b0 || ext_mem_cs !== 1'b0) begin bad++; $display("FAIL spurious_ack d=%0b i=%0b cs=%0b exp=0", d_ack_o, i_ack_o, ext_mem_cs); end
        total++; if (d_data_o !== d_last || i_data_o !== i_last) begin bad++; $display("FAIL spurious_data d=%0h i=%0h", d_data_o, i_data_o); end
        tick();
        total++; if (d_ack_o !== 1'b0 || i_ack_o !== 1'b0) begin bad++; $display("FAIL spurious_late d=%0b i=%0b exp=0", d_ack_o, i_ack_o); end
        i_addr_i = {4'h1, 28'($urandom)}; i_we_i = 1'b0; i_cs_i = 1'b1;
        tick();
        model_grant(1'b0, 1'b1, pick);
        total++; if (ext_mem_cs !== 1'b1 || ext_mem_addr !== i_addr_i) begin bad++; $display("FAIL midrst_grant cs=%0b addr=%0h exp=%0h", ext_mem_cs, ext_mem_addr, i_addr_i); end
        i_cs_i = 1'b0; rst = 1'b0;
        tick();
        m_streak = 0; d_last = '0; i_last = '0;
        total++; if (ext_mem_cs !== 1'b0 || i_ack_o !== 1'b0) begin bad++; $display("FAIL midrst_abort cs=%0b ack=%0b exp=0/0", ext_mem_cs, i_ack_o); end
        rst = 1'b1;
        tick();
        total++; if (i_ack_o !== 1'b0 || ext_mem_cs !== 1'b0) begin bad++; $display("FAIL midrst_idle ack=%0b cs=%0b exp=0/0", i_ack_o, ext_mem_cs); end
        d_addr_i = {4'hD, 28'($urandom)}; d_we_i = 1'b0; d_cs_i = 1'b1;
        tick();
        model_grant(1'b1, 1'b0, pick);
        total++; if (ext_mem_cs !== 1'b1 || ext_mem_addr !== d_addr_i) begin bad++; $display("FAIL midrst_next cs=%0b addr=%0h exp=%0h", ext_mem_cs, ext_mem_addr, d_addr_i); end
        d_last = rand_line();
        do_ack(d_last);
        total++; if (d_ack_o !== 1'b1 || d_data_o !== d_last) begin bad++; $display("FAIL zero_wait_ack ack=%0b data=%0h exp=%0h", d_ack_o, d_data_o, d_last); end
        d_cs_i = 1'b0;
        tick(); tick();
    endtask

    task automatic test_addr_hold();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] w;
        bit pick;
        a = {4'hD, 28'($urandom)}; w = rand_line();
        d_addr_i = a; d_we_i = 1'b1; d_data_i = w; d_cs_i = 1'b1;
        tick();
        model_grant(1'b1, 1'b0, pick);
        total++; if (ext_mem_addr !== a) begin bad++; $display("FAIL hold_latch got=%0h exp=%0h", ext_mem_addr, a); end
        d_addr_i = ~a; d_we_i = 1'b0; d_data_i = ~w;
        tick();
        total++; if (ext_mem_addr !== a || ext_mem_we !== 1'b1 || ext_mem_data_o !== w) begin bad++; $display("FAIL hold_change addr=%0h we=%0b exp=%0h/1", ext_mem_addr, ext_mem_we, a); end
        tick();
        total++; if (ext_mem_addr !== a) begin bad++; $display("FAIL hold_late got=%0h exp=%0h", ext_mem_addr, a); end
        do_ack(rand_line());
        total++; if (d_ack_o !== 1'b1 || d_data_o !== d_last) begin bad++; $display("FAIL hold_wr_ack ack=%0b data=%0h exp=%0h", d_ack_o, d_data_o, d_last); end
        d_cs_i = 1'b0;
        tick(); tick();
    endtask

    task automatic test_random();
        bit                pend_d, pend_i, pick, got_i;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_wdata, rd;
        logic              exp_we;
        int                lows;
        pend_d = 1'b0; pend_i = 1'b0;
        for (int r = 0; r < 40; r++) begin
            if (!pend_d && $urandom_range(0, 1) == 1) pend_d = 1'b1;
            if (!pend_i && $urandom_range(0, 1) == 1) pend_i = 1'b1;
            if (!pend_d && !pend_i) begin
                if ($urandom_range(0, 1) == 1) pend_d = 1'b1; else pend_i = 1'b1;
            end
            if (pend_d && !d_cs_i) begin d_addr_i = {4'hD, 28'($urandom)}; d_we_i = 1'($urandom); d_data_i = rand_line(); end
            if (pend_i && !i_cs_i) begin i_addr_i = {4'h1, 28'($urandom)}; i_we_i = 1'($urandom); i_data_i = rand_line(); end
            d_cs_i = pend_d; i_cs_i = pend_i;
            lows = 0;
            tick();
            while (ext_mem_cs !== 1'b1 && lows < 20) begin lows++; tick(); end
            total++; if (ext_mem_cs !== 1'b1) begin bad++; $display("FAIL rnd_timeout r=%0d cs=%0b exp=1", r, ext_mem_cs); end
            if (r > 0) begin
                total++; if (lows + 1 != 2) begin bad++; $display("FAIL rnd_gap r=%0d got=%0d exp=2", r, lows + 1); end
            end
            model_grant(pend_d, pend_i, pick);
            got_i = (ext_mem_addr[ADDR_W-1 -: 4] == 4'h1);
            total++; if (got_i !== pick) begin bad++; $display("FAIL rnd_winner r=%0d got_i=%0b exp_i=%0b", r, got_i, pick); end
            exp_addr  = pick ? i_addr_i : d_addr_i;
            exp_we    = pick ? i_we_i : d_we_i;
            exp_wdata = pick ? i_data_i : d_data_i;
            total++; if (ext_mem_addr !== exp_addr || ext_mem_we !== exp_we || ext_mem_data_o !== exp_wdata) begin bad++; $display("FAIL rnd_fields r=%0d addr=%0h exp=%0h", r, ext_mem_addr, exp_addr); end
            if (pick) i_addr_i = {4'h1, 28'($urandom)}; else d_addr_i = {4'hD, 28'($urandom)};
            repeat ($urandom_range(0, 4)) tick();
            total++; if (ext_mem_addr !== exp_addr || ext_mem_cs !== 1'b1) begin bad++; $display("FAIL rnd_hold r=%0d addr=%0h exp=%0h", r, ext_mem_addr, exp_addr); end
            rd = rand_line();
            do_ack(rd);
            if (pick && !exp_we) i_last = rd;
            if (!pick && !exp_we) d_last = rd;
            total++; if (d_ack_o !== !pick || i_ack_o !== pick) begin bad++; $display("FAIL rnd_ack r=%0d d=%0b i=%0b exp_i=%0b", r, d_ack_o, i_ack_o, pick); end
            total++; if (d_data_o !== d_last || i_data_o !== i_last) begin bad++; $display("FAIL rnd_rdata r=%0d d=%0h i=%0h", r, d_data_o, i_data_o); end
            if (pick) begin pend_i = 1'b0; i_cs_i = 1'b0; end
            else begin pend_d = 1'b0; d_cs_i = 1'b0; end
        end
        d_cs_i = 1'b0; i_cs_i = 1'b0;
        tick(); tick();
    endtask

    initial begin
        rst = 1'b0;
        d_addr_i = '0; d_cs_i = 1'b0; d_we_i = 1'b0; d_data_i = '0;
        i_addr_i = '0; i_cs_i = 1'b0; i_we_i = 1'b0; i_data_i = '0;
        ext_mem_data_i = '0; ext_mem_ack = 1'b0;
        test_reset();
        test_d_read();
        test_i_write();
        test_starvation();
        test_corner();
        test_addr_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
